// File: rtl/axi_write_master.sv
// -----------------------------------------------------------------------------
// axi_write_master
//   Single-outstanding write master for the simplified AXI slave. A command
//   accepted on the cmd_* handshake is launched on AW and W at the same time.
//   The two channels may complete in either order. The master then waits on B
//   under a watchdog, so a slave that never raises bvalid cannot hang it.
//   Each write ends with a one-cycle resp_done pulse. resp_timeout qualifies
//   that pulse.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset (0 = reset)
//   cmd_valid/cmd_ready       command handshake
//   cmd_addr, cmd_data        command payload
//   awaddr/awvalid/awready    AW channel
//   wdata/wvalid/wready       W channel
//   bvalid/bready             B channel
//   resp_done, resp_timeout   completion pulse; resp_timeout=1 means the watchdog expired
//   late_b_err                sticky flag: bvalid was seen outside WAIT_B
//   ok_cnt, timeout_cnt       saturating completion statistics
// -----------------------------------------------------------------------------
module axi_write_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bvalid,
   output logic              bready,
   output logic              resp_done,
   output logic              resp_timeout,
   output logic              late_b_err,
   output logic [CNT_W-1:0]  ok_cnt,
   output logic [CNT_W-1:0]  timeout_cnt
);

   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_B
   } state_e;

   state_e              state_q, state_d;
   logic                live_q;          // 0 until the first edge after reset release
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                resp_done_q, resp_done_d;
   logic                resp_timeout_q, resp_timeout_d;
   logic                late_b_err_q, late_b_err_d;
   logic [CNT_W-1:0]    ok_cnt_q, ok_cnt_d;
   logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;

   // cmd_ready stays low during reset and rises one edge after release.
   assign cmd_ready    = live_q && (state_q == S_IDLE);
   assign bready       = (state_q == S_WAIT_B);
   assign awaddr       = awaddr_q;
   assign wdata        = wdata_q;
   assign awvalid      = awvalid_q;
   assign wvalid       = wvalid_q;
   assign resp_done    = resp_done_q;
   assign resp_timeout = resp_timeout_q;
   assign late_b_err   = late_b_err_q;
   assign ok_cnt       = ok_cnt_q;
   assign timeout_cnt  = timeout_cnt_q;

   always_comb begin
      // NOTE: every variable gets a default here first, so no path can leave a value unassigned and infer a latch.
      state_d        = state_q;
      awaddr_d       = awaddr_q;
      wdata_d        = wdata_q;
      awvalid_d      = awvalid_q;
      wvalid_d       = wvalid_q;
      wd_d           = wd_q;
      ok_cnt_d       = ok_cnt_q;
      timeout_cnt_d  = timeout_cnt_q;
      resp_done_d    = 1'b0;
      resp_timeout_d = 1'b0;
      // A B beat outside WAIT_B is never consumed. It is only flagged.
      late_b_err_d   = late_b_err_q || (bvalid && (state_q != S_WAIT_B));

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               awaddr_d  = cmd_addr;
               wdata_d   = cmd_data;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            // Look at the next-state valids so that a handshake in this cycle counts.
            if (!awvalid_d && !wvalid_d) begin
               wd_d    = '0;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            // bvalid is checked before the watchdog, so a B beat on the last cycle is reported OK.
            if (bvalid) begin
               resp_done_d = 1'b1;
               if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_W'(1);
               state_d     = S_IDLE;
            end else if (wd_q == WD_LAST) begin
               resp_done_d    = 1'b1;
               resp_timeout_d = 1'b1;
               if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
               state_d        = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         live_q         <= 1'b0;
         awaddr_q       <= '0;
         wdata_q        <= '0;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         wd_q           <= '0;
         resp_done_q    <= 1'b0;
         resp_timeout_q <= 1'b0;
         late_b_err_q   <= 1'b0;
         ok_cnt_q       <= '0;
         timeout_cnt_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment, so every flop samples the pre-edge values.
         state_q        <= state_d;
         live_q         <= 1'b1;
         awaddr_q       <= awaddr_d;
         wdata_q        <= wdata_d;
         awvalid_q      <= awvalid_d;
         wvalid_q       <= wvalid_d;
         wd_q           <= wd_d;
         resp_done_q    <= resp_done_d;
         resp_timeout_q <= resp_timeout_d;
         late_b_err_q   <= late_b_err_d;
         ok_cnt_q       <= ok_cnt_d;
         timeout_cnt_q  <= timeout_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi_write_master.sv
module tb_axi_write_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 16;
   localparam int CW  = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [DW-1:0] wdata;
   logic          wvalid;
   logic          wready = 1'b0;
   logic          bvalid = 1'b0;
   logic          bready;
   logic          resp_done;
   logic          resp_timeout;
   logic          late_b_err;
   logic [CW-1:0] ok_cnt;
   logic [CW-1:0] timeout_cnt;

   always #5 clk = ~clk;

   axi_write_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready),
      .resp_done(resp_done), .resp_timeout(resp_timeout), .late_b_err(late_b_err),
      .ok_cnt(ok_cnt), .timeout_cnt(timeout_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard: the stimulus pushes, the monitor pops.
   logic [AW-1:0] exp_aw[$];
   logic [DW-1:0] exp_w[$];
   bit            exp_resp[$];
   int            m_ok = 0;
   int            m_to = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic          aw_pend = 1'b0, w_pend = 1'b0;
   logic [AW-1:0] aw_prev = '0;
   logic [DW-1:0] w_prev  = '0;
   always @(negedge clk) begin
      if (!rst) begin
         aw_pend = 1'b0;
         w_pend  = 1'b0;
      end else begin
         if (aw_pend) begin
            check("aw_hold_valid", awvalid, 1'b1);
            check("aw_hold_addr", awaddr, aw_prev);
         end
         if (w_pend) begin
            check("w_hold_valid", wvalid, 1'b1);
            check("w_hold_data", wdata, w_prev);
         end
         if (awvalid && awready) begin
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else check("awaddr", awaddr, exp_aw.pop_front());
         end
         if (wvalid && wready) begin
            if (exp_w.size() == 0) fail_now("w_unexpected");
            else check("wdata", wdata, exp_w.pop_front());
         end
         if (resp_done) begin
            if (exp_resp.size() == 0) fail_now("resp_unexpected");
            else begin
               bit e;
               e = exp_resp.pop_front();
               check("resp_timeout", resp_timeout, e);
               if (e) begin if (m_to < CNT_MAX) m_to++; end
               else   begin if (m_ok < CNT_MAX) m_ok++; end
               check("sb_ok_cnt", ok_cnt, m_ok);
               check("sb_timeout_cnt", timeout_cnt, m_to);
            end
         end else begin
            check("resp_timeout_idle", resp_timeout, 1'b0);
         end
         aw_pend = awvalid && !awready;
         aw_prev = awaddr;
         w_pend  = wvalid && !wready;
         w_prev  = wdata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous clear, and releases.
   task automatic apply_reset();
      rst = 1'b0;
      #1;
      exp_aw.delete();
      exp_w.delete();
      exp_resp.delete();
      m_ok = 0;
      m_to = 0;
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_bready", bready, 1'b0);
      check("rst_resp_done", resp_done, 1'b0);
      check("rst_resp_timeout", resp_timeout, 1'b0);
      check("rst_late_b_err", late_b_err, 1'b0);
      check("rst_ok_cnt", ok_cnt, 0);
      check("rst_timeout_cnt", timeout_cnt, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      step();
      step();
      check("rst_hold_resp_done", resp_done, 1'b0);
      rst = 1'b1;
      #1;
      check("rel_cmd_ready_low", cmd_ready, 1'b0);
      step();
      check("rel_cmd_ready_high", cmd_ready, 1'b1);
   endtask

   // Presents one command, pushes its expectations, and returns in the cycle after acceptance.
   task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_to);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (!cmd_ready) fail_now("cmd_ready_wait");
      exp_aw.push_back(a);
      exp_w.push_back(d);
      exp_resp.push_back(exp_to);
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!resp_done && n < max) begin
         step();
         n++;
      end
      if (!resp_done) fail_now("resp_done_wait");
   endtask

   initial begin
      int nb, aw_n, w_n;
      bit early_b;
      #2;
      apply_reset();

      // 1: immediate readies; B in the first bready cycle
      awready = 1'b1;
      wready  = 1'b1;
      issue(32'h10, 32'hA5A5_A5A5, 1'b0);
      check("t1_awvalid", awvalid, 1'b1);
      check("t1_wvalid", wvalid, 1'b1);
      check("t1_awaddr", awaddr, 32'h10);
      check("t1_wdata", wdata, 32'hA5A5_A5A5);
      check("t1_cmd_ready_busy", cmd_ready, 1'b0);
      step();
      check("t1_bready", bready, 1'b1);
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      check("t1_resp_done", resp_done, 1'b1);
      check("t1_resp_timeout", resp_timeout, 1'b0);
      check("t1_cmd_ready", cmd_ready, 1'b1);
      check("t1_ok_cnt", ok_cnt, 1);

      // 2: bvalid never arrives; expect exactly 16 bready cycles
      issue(32'h20, 32'h1111_1111, 1'b1);
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_done) break;
         if (bready) nb++;
         step();
      end
      check("t2_wait_cycles", nb, TO);
      check("t2_resp_done", resp_done, 1'b1);
      check("t2_resp_timeout", resp_timeout, 1'b1);
      check("t2_timeout_cnt", timeout_cnt, 1);
      check("t2_bready_off", bready, 1'b0);

      // 3: AW ready delayed by 5 cycles, W ready immediately
      awready = 1'b0;
      issue(32'h30, 32'h2222_2222, 1'b0);
      aw_n = 0;
      w_n = 0;
      early_b = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         awready = (i == 6);
         if (awvalid) aw_n++;
         if (wvalid) w_n++;
         if (bready) early_b = 1'b1;
         step();
      end
      check("t3_aw_cycles", aw_n, 6);
      check("t3_w_cycles", w_n, 1);
      check("t3_no_early_bready", early_b, 1'b0);
      check("t3_awvalid_off", awvalid, 1'b0);
      check("t3_bready", bready, 1'b1);
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      check("t3_resp_done", resp_done, 1'b1);
      check("t3_ok_cnt", ok_cnt, 2);

      // 4: B on the final watchdog cycle wins over the timeout
      awready = 1'b1;
      issue(32'h40, 32'h3333_3333, 1'b0);
      step();
      repeat (TO - 1) step();
      check("t4_bready_last", bready, 1'b1);
      check("t4_no_done_yet", resp_done, 1'b0);
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      check("t4_resp_done", resp_done, 1'b1);
      check("t4_resp_timeout", resp_timeout, 1'b0);
      check("t4_ok_cnt", ok_cnt, 3);
      check("t4_timeout_cnt", timeout_cnt, 1);

      // 5a: reset while AW/W are stalled in SEND drops the valids at once
      awready = 1'b0;
      wready  = 1'b0;
      issue(32'h50, 32'h4444_4444, 1'b0);
      check("t5_send_awvalid", awvalid, 1'b1);
      apply_reset();
      // 5b: reset in WAIT_B, then a stray B beat in IDLE
      awready = 1'b1;
      wready  = 1'b1;
      issue(32'h60, 32'h5555_5555, 1'b0);
      step();
      step();
      check("t5_in_wait_b", bready, 1'b1);
      exp_resp.delete();
      apply_reset();
      check("t5_late_clear", late_b_err, 1'b0);
      bvalid = 1'b1;
      #1;
      check("t5_idle_bready", bready, 1'b0);
      step();
      bvalid = 1'b0;
      check("t5_late_b_err", late_b_err, 1'b1);
      check("t5_no_done", resp_done, 1'b0);
      check("t5_ok_cnt", ok_cnt, 0);
      check("t5_cmd_ready", cmd_ready, 1'b1);

      // 6: 20 back-to-back timeouts saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         issue(32'h100 + 32'(i * 4), 32'(i), 1'b1);
         wait_done(40);
      end
      check("t6_timeout_sat", timeout_cnt, CNT_MAX);

      // 6b: random ready patterns; B is answered as soon as bready is seen
      for (int i = 0; i < 100; i++) begin
         int n;
         awready = 1'($urandom_range(0, 1));
         wready  = 1'($urandom_range(0, 1));
         issue(32'h1000 + 32'(i * 4), $urandom, 1'b0);
         n = 0;
         while (!resp_done && n < 200) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = bready;
            step();
            n++;
         end
         bvalid = 1'b0;
         if (!resp_done) fail_now("rand_resp_done_wait");
      end
      check("t6_ok_sat", ok_cnt, CNT_MAX);
      check("t6_timeout_kept", timeout_cnt, CNT_MAX);
      step();
      check("sb_resp_drained", exp_resp.size(), 0);
      check("sb_aw_drained", exp_aw.size(), 0);
      check("sb_w_drained", exp_w.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
